seg_scan_mux: RTL and testbench

- Parametrised successor to the board-level display path.
- Selects one of NUM_CH 32-bit debug channels, either by switch or by auto-rotation. Latches the selection tear-free once per scan frame and drives an 8-digit common-anode 7-segment display by time-multiplexed scanning.
- Sits in the board top between CPU debug taps (pc, instr, registers) and the board pins.
- Adds three features the fixed 4-way version lacks: auto-cycle mode, hold/freeze, and a channel indicator on the decimal points.

---
 rtl/seg_scan_mux_pkg.sv | 21 ++
 rtl/seg_scan_mux_hex_to_seg7.sv | 11 +
 rtl/seg_scan_mux.sv | 116 +++++++++++
 tb/tb_seg_scan_mux.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the scanned 7-segment display path: the hex glyph table,
// blanking codes and digit count.
package seg_scan_mux_pkg;

  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEL_NONE  = 8'hFF;

  typedef logic [6:0] seg7_t;

  // Active-low {g,f,e,d,c,b,a} glyphs; nibble 0 sits in the low 7 bits.
  localparam logic [16*7-1:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic seg7_t hex_pattern(input logic [3:0] nibble);
    return HEX_TABLE[7*int'(nibble) +: 7];
  endfunction

endpackage

// File: rtl/seg_scan_mux_hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for one 7-segment digit.
module hex_to_seg7
  import seg_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_pattern(nibble);

endmodule

// File: rtl/seg_scan_mux.sv
// Channel selector with per-frame tear-free latch driving an 8-digit
// common-anode display by time-multiplexed scanning.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int CYCLE_FRAMES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [NUM_CH*32-1:0]   ch_data,
  input  logic [SEL_W-1:0]       ch_sel,
  input  logic                   auto_mode,
  input  logic                   hold,
  output logic [7:0]             o_seg,
  output logic [7:0]             o_sel,
  output logic [SEL_W-1:0]       ch_idx
);

  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int FC_W  = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam int DIG_W = $clog2(DIGITS);

  logic [SC_W-1:0]  scan_cnt_reg;
  logic [DIG_W-1:0] digit_reg;
  logic [FC_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic [SEL_W-1:0] cur_ch_reg, cur_ch_next;
  logic [31:0]      frame_val_reg;
  logic [7:0]       o_seg_reg, o_sel_reg;

  logic        tick, frame_wrap, dp_n;
  logic [31:0] sel_val;
  logic [3:0]  nibble;
  logic [6:0]  seg7;
  logic [31:0] ch_word [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_word[gi] = ch_data[32*gi +: 32];
    end
  endgenerate

  assign tick       = (scan_cnt_reg == SC_W'(SCAN_DIV - 1));
  assign frame_wrap = tick && (digit_reg == DIG_W'(DIGITS - 1));

  // Next channel; hold overrides both manual reload and auto-advance.
  always_comb begin
    cur_ch_next    = cur_ch_reg;
    frame_cnt_next = frame_cnt_reg;
    if (!auto_mode) begin
      frame_cnt_next = '0;
      if (frame_wrap) cur_ch_next = ch_sel;
    end else if (frame_wrap) begin
      if (frame_cnt_reg == FC_W'(CYCLE_FRAMES - 1)) begin
        frame_cnt_next = '0;
        cur_ch_next    = (cur_ch_reg >= SEL_W'(NUM_CH - 1)) ? '0 : cur_ch_reg + 1'b1;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
    if (hold) begin
      cur_ch_next    = cur_ch_reg;
      frame_cnt_next = frame_cnt_reg;
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch_next == SEL_W'(k)) sel_val = ch_word[k];
    end
  end

  assign nibble = frame_val_reg[{digit_reg, 2'b00} +: 4];
  assign dp_n   = (32'(digit_reg) == 32'(cur_ch_reg)) ? 1'b0 : 1'b1;

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (seg7)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg  <= '0;
      digit_reg     <= '0;
      frame_cnt_reg <= '0;
      cur_ch_reg    <= '0;
      frame_val_reg <= '0;
      o_seg_reg     <= SEG_BLANK;
      o_sel_reg     <= SEL_NONE;
    end else begin
      scan_cnt_reg  <= tick ? '0 : scan_cnt_reg + 1'b1;
      if (tick) digit_reg <= digit_reg + 1'b1;
      cur_ch_reg    <= cur_ch_next;
      frame_cnt_reg <= frame_cnt_next;
      if (frame_wrap && !hold) frame_val_reg <= sel_val;
      if (!ena) begin
        o_seg_reg <= SEG_BLANK;
        o_sel_reg <= SEL_NONE;
      end else if (tick) begin
        o_sel_reg <= ~(8'b1 << digit_reg);
        o_seg_reg <= {dp_n, seg7};
      end
    end
  end

  assign o_seg  = o_seg_reg;
  assign o_sel  = o_sel_reg;
  assign ch_idx = cur_ch_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench: expected digit frames are queued when stimulus is set and
// popped at each scan update of the display.
module tb_seg_scan_mux;

  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst, ena, auto_mode, hold;
  logic [127:0] ch_data;
  logic [1:0]   ch_sel;
  logic [7:0]   o_seg, o_sel, o_seg3, o_sel3;
  logic [1:0]   ch_idx, ch_idx3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] exp_q [$];
  logic [1:0]  ch_q [$];

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_CH(4), .SEL_W(2), .SCAN_DIV(SD), .CYCLE_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .ch_data(ch_data), .ch_sel(ch_sel),
    .auto_mode(auto_mode), .hold(hold), .o_seg(o_seg), .o_sel(o_sel), .ch_idx(ch_idx)
  );

  seg_scan_mux #(.NUM_CH(3), .SEL_W(2), .SCAN_DIV(SD), .CYCLE_FRAMES(2)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .ch_data(ch_data[95:0]), .ch_sel(ch_sel),
    .auto_mode(auto_mode), .hold(hold), .o_seg(o_seg3), .o_sel(o_sel3), .ch_idx(ch_idx3)
  );

  function automatic logic [15:0] exp_entry(int d, logic [31:0] v, int ch);
    logic [7:0] sel, seg;
    sel = ~(8'b1 << d);
    seg = {(d == ch) ? 1'b0 : 1'b1, hex_ref[v[4*d +: 4]]};
    return {sel, seg};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to the next display update; d is the digit it shows.
  task automatic next_update(output int d);
    int n = 0;
    do begin
      step();
      n++;
    end while ((cyc % SD) != 0 && n < 2*SD);
    d = ((cyc / SD) - 1) % 8;
  endtask

  // Advance through the next frame wrap (the digit-7 update).
  task automatic to_wrap();
    int d = 0;
    int n = 0;
    do begin
      next_update(d);
      n++;
    end while (d != 7 && n < 10);
    if (d != 7) begin
      failures++;
      $display("FAIL to_wrap timeout: digit=%0d required 7", d);
    end
  endtask

  task automatic push_frame(int first, int last, logic [31:0] v, int ch);
    for (int d = first; d <= last; d++) exp_q.push_back(exp_entry(d, v, ch));
  endtask

  task automatic pop_compare(string name, int n, bit use3);
    int d;
    logic [15:0] e, got;
    for (int i = 0; i < n; i++) begin
      next_update(d);
      e   = exp_q.pop_front();
      got = use3 ? {o_sel3, o_seg3} : {o_sel, o_seg};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s digit=%0d got sel=%h seg=%h required sel=%h seg=%h",
                 name, d, got[15:8], got[7:0], e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; auto_mode = 1'b0; hold = 1'b0; ch_sel = 2'd0;
    ch_data = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({o_seg, o_sel, ch_idx, o_seg3, o_sel3, ch_idx3} !== {8'hFF, 8'hFF, 2'd0, 8'hFF, 8'hFF, 2'd0}) begin
        failures++;
        $display("FAIL reset_state cycle=%0d got seg=%h sel=%h idx=%0d required FF FF 0",
                 i, o_seg, o_sel, ch_idx);
      end
    end
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < SD - 1; i++) begin
      step();
      checks++;
      if (o_sel !== 8'hFF) begin
        failures++;
        $display("FAIL reset_pre_tick cycle=%0d got sel=%h required FF", cyc, o_sel);
      end
    end
    exp_q.push_back(exp_entry(0, 32'h0, 0));
    pop_compare("reset_first_update", 1, 1'b0);
  endtask

  task automatic test_manual();
    ch_data[64 +: 32] = 32'h1234ABCD;
    ch_sel = 2'd2;
    to_wrap();
    ch_q.push_back(2'd2);
    push_frame(0, 7, 32'h1234ABCD, 2);
    checks++;
    if (ch_idx !== ch_q[0]) begin
      failures++;
      $display("FAIL manual_ch_idx got %0d required %0d", ch_idx, ch_q[0]);
    end
    void'(ch_q.pop_front());
    pop_compare("manual_scan", 8, 1'b0);
  endtask

  task automatic test_auto();
    do_reset();
    ch_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    auto_mode = 1'b1;
    for (int w = 1; w <= 8; w++) ch_q.push_back(2'((w / 2) % 4));
    for (int w = 1; w <= 8; w++) begin
      logic [1:0] e;
      to_wrap();
      e = ch_q.pop_front();
      checks++;
      if (ch_idx !== e) begin
        failures++;
        $display("FAIL auto_ch_idx wrap=%0d got %0d required %0d", w, ch_idx, e);
      end
    end
    // After 8 wraps cur_ch is 0 again, showing channel 0's data.
    push_frame(0, 7, 32'h00000000, 0);
    pop_compare("auto_frame", 8, 1'b0);
    auto_mode = 1'b0;
  endtask

  task automatic test_hold();
    ch_sel = 2'd1;
    ch_data[32 +: 32] = 32'hCAFE0123;
    to_wrap();
    push_frame(0, 2, 32'hCAFE0123, 1);
    pop_compare("hold_pre", 3, 1'b0);
    hold = 1'b1;
    ch_data[32 +: 32] = 32'h89ABCDEF;
    ch_data[96 +: 32] = 32'h55667788;
    ch_sel = 2'd3;
    push_frame(3, 7, 32'hCAFE0123, 1);
    push_frame(0, 1, 32'hCAFE0123, 1);
    pop_compare("hold_frozen", 7, 1'b0);
    checks++;
    if (ch_idx !== 2'd1) begin
      failures++;
      $display("FAIL hold_ch_idx got %0d required 1", ch_idx);
    end
    hold = 1'b0;
    push_frame(2, 7, 32'hCAFE0123, 1);
    push_frame(0, 7, 32'h55667788, 3);
    pop_compare("hold_release", 14, 1'b0);
    checks++;
    if (ch_idx !== 2'd3) begin
      failures++;
      $display("FAIL hold_release_ch_idx got %0d required 3", ch_idx);
    end
  endtask

  task automatic test_oor_enable();
    int d;
    ch_sel = 2'd3;
    to_wrap();
    checks++;
    if (ch_idx3 !== 2'd3) begin
      failures++;
      $display("FAIL oor_ch_idx got %0d required 3", ch_idx3);
    end
    push_frame(0, 7, 32'h0, 3);
    pop_compare("oor_zero", 8, 1'b1);
    ena = 1'b0;
    for (int i = 0; i < SD + 1; i++) begin
      step();
      checks++;
      if ({o_sel, o_seg, o_sel3, o_seg3} !== {4{8'hFF}}) begin
        failures++;
        $display("FAIL ena_blank step=%0d got sel=%h seg=%h sel3=%h seg3=%h required FF",
                 i, o_sel, o_seg, o_sel3, o_seg3);
      end
    end
    ena = 1'b1;
    d = ((cyc / SD)) % 8;
    exp_q.push_back(exp_entry(d, 32'h0, 3));
    pop_compare("ena_resume", 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int d = 0;
    int n = 0;
    do begin
      next_update(d);
      n++;
    end while (d != 4 && n < 10);
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({o_sel, o_seg, ch_idx} !== {8'hFF, 8'hFF, 2'd0}) begin
      failures++;
      $display("FAIL reset_mid got sel=%h seg=%h idx=%0d required FF FF 0", o_sel, o_seg, ch_idx);
    end
    rst = 1'b0;
    cyc = 0;
    push_frame(0, 7, 32'h0, 0);
    pop_compare("reset_mid_frame", 8, 1'b0);
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_hold();
    test_oor_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
